inversion_arbiter: RTL and testbench

Shares one modular `inversion` unit among `NUM_REQ` requesters, such as the point-add, point-double and coordinate-conversion engines. It arbitrates round-robin, latches the winning operand and sequences the unit's enable/ready handshake. It returns each inverse on a shared result bus with a one-cycle per-requester done strobe. It sits between the ECC point-arithmetic engines and the single `inversion` instance.

---
 rtl/inversion_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_inversion_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inversion_arbiter.sv
// Round-robin arbiter sharing one modular inversion unit among NUM_REQ requesters.
// Optional INV_ZERO_CHECK_EN: zero operands bypass the unit and complete with err=1.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module inversion_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = `DATAWIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   operand,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATAWIDTH-1:0]           result,
  output logic                           busy,
`ifdef INV_ZERO_CHECK_EN
  output logic                           err,
`endif
  output logic                           inv_enable,
  output logic [DATAWIDTH-1:0]           inv_x,
  input  logic [DATAWIDTH-1:0]           inv_inverse,
  input  logic                           inv_ready,
  output logic [1:0]                     dbg_state
);

  // Handshake: req[i] is a level held (with operand[i] stable) until the
  // one-cycle ack[i]; the operation then always completes with one done[i].

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0]   NREQ_W = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST   = IW'(NUM_REQ-1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gid_q, gid_d;
  logic                   cnt_q, cnt_d;
  logic                   rdy_q, rdy_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [DATAWIDTH-1:0]   result_q, result_d;
  logic                   busy_q, busy_d;
  logic                   inv_enable_q, inv_enable_d;
  logic [DATAWIDTH-1:0]   inv_x_q, inv_x_d;
`ifdef INV_ZERO_CHECK_EN
  logic                   err_q, err_d;
`endif

  logic [DATAWIDTH-1:0]   op_arr [NUM_REQ];
  logic                   win_found;
  logic [IW-1:0]          win_idx;
  logic [DATAWIDTH-1:0]   win_op;
  logic                   zero_op;
  logic [IW:0]            cand;
  logic [IW-1:0]          cand_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = operand[g*DATAWIDTH +: DATAWIDTH];
  end

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      cand_idx = cand[IW-1:0];
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_op = op_arr[win_idx];
`ifdef INV_ZERO_CHECK_EN
    zero_op = (win_op == '0);
`else
    zero_op = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gid_d        = gid_q;
    cnt_d        = cnt_q;
    rdy_d        = inv_ready;
    ack_d        = '0;
    done_d       = '0;
    result_d     = result_q;
    inv_enable_d = 1'b0;
    inv_x_d      = inv_x_q;
`ifdef INV_ZERO_CHECK_EN
    err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gid_d   = win_idx;
          inv_x_d = win_op;
          ack_d   = NUM_REQ'(1) << win_idx;
          cnt_d   = 1'b0;
          if (zero_op) begin
            // The unit never terminates on x=0, so complete here instead.
            state_d  = S_DONE;
            result_d = '0;
            done_d   = NUM_REQ'(1) << win_idx;
`ifdef INV_ZERO_CHECK_EN
            err_d    = 1'b1;
`endif
          end else begin
            state_d      = S_ISSUE;
            inv_enable_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!cnt_q) begin
          cnt_d        = 1'b1;
          inv_enable_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Only a fresh rising edge counts; a stale high level is ignored.
        if (inv_ready && !rdy_q) begin
          result_d = inv_inverse;
          done_d   = NUM_REQ'(1) << gid_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (gid_q == LAST) ? '0 : gid_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      gid_q        <= '0;
      cnt_q        <= 1'b0;
      rdy_q        <= 1'b1;
      ack_q        <= '0;
      done_q       <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      inv_enable_q <= 1'b0;
      inv_x_q      <= '0;
`ifdef INV_ZERO_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gid_q        <= gid_d;
      cnt_q        <= cnt_d;
      rdy_q        <= rdy_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      inv_enable_q <= inv_enable_d;
      inv_x_q      <= inv_x_d;
`ifdef INV_ZERO_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign result     = result_q;
  assign busy       = busy_q;
  assign inv_enable = inv_enable_q;
  assign inv_x      = inv_x_q;
  assign dbg_state  = state_q;
`ifdef INV_ZERO_CHECK_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_inversion_arbiter.sv
// Directed bench for inversion_arbiter with a behavioural inversion unit (p = 65521).
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module tb_inversion_arbiter;
  localparam int DW  = `DATAWIDTH;
  localparam int NR  = 4;
  localparam longint P = 65521;
  localparam int LAT = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] operand;
  logic [NR-1:0]   ack, done;
  logic [DW-1:0]   result;
  logic            busy;
  logic            inv_enable;
  logic [DW-1:0]   inv_x;
  logic [DW-1:0]   inv_inverse = '0;
  logic            inv_ready = 1'b1;
  logic [1:0]      dbg_state;
`ifdef INV_ZERO_CHECK_EN
  logic            err;
`endif

  int errors = 0;
  int checks = 0;

  inversion_arbiter #(.NUM_REQ(NR), .DATAWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .operand(operand),
    .ack(ack), .done(done), .result(result), .busy(busy),
`ifdef INV_ZERO_CHECK_EN
    .err(err),
`endif
    .inv_enable(inv_enable), .inv_x(inv_x), .inv_inverse(inv_inverse),
    .inv_ready(inv_ready), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Behavioural inversion unit: no reset, sticky ready, fixed latency.
  function automatic logic [DW-1:0] modinv(input logic [DW-1:0] x);
    longint r, b, e;
    r = 1; b = longint'(x); e = P - 2;
    while (e > 0) begin
      if (e[0]) r = (r * b) % P;
      b = (b * b) % P;
      e = e >>> 1;
    end
    return r[DW-1:0];
  endfunction

  bit            m_busy = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_x = '0;

  always @(posedge clk) begin
    if (!m_busy && inv_enable === 1'b1) begin
      m_busy    <= 1'b1;
      inv_ready <= 1'b0;
      m_cnt     <= LAT;
      m_x       <= inv_x;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        inv_ready   <= 1'b1;
        inv_inverse <= modinv(m_x);
        m_busy      <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Driver and checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input string tag, input int idx, input logic [DW-1:0] exp_res,
                       input bit rereq0, output int ack_wait);
    int n;
    int en_cnt;
    logic [NR-1:0] exp_oh;
    exp_oh = NR'(1) << idx;
    n = 0;
    en_cnt = 0;
    while (ack === '0 && n < 20) begin
      step();
      n++;
    end
    ack_wait = n;
    check({tag, "_ack"}, 32'(ack), 32'(exp_oh));
    if (inv_enable === 1'b1) en_cnt++;
    req = req & ~ack;
    n = 0;
    while (done === '0 && n < 60) begin
      step();
      n++;
      if (inv_enable === 1'b1) en_cnt++;
    end
    check({tag, "_done"}, 32'(done), 32'(exp_oh));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'd2);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    if (rereq0) req[0] = 1'b1;
  endtask

  // Directed sequence
  initial begin
    int n;
    int w;
    int en_extra;
    int seen;
    logic [DW-1:0] ops [NR];
    logic [DW-1:0] exps [NR];

    rst_n = 1'b0;
    req = '0;
    operand = '0;
    repeat (3) step();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_inv_enable", 32'(inv_enable), 32'd0);
    check("rst_inv_x", 32'(inv_x), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Single request, operand 1, cycle-exact enable window
    operand[0*DW +: DW] = 16'd1;
    req = 4'b0001;
    step();
    check("t1_ack", 32'(ack), 32'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_en_a", 32'(inv_enable), 32'd1);
    check("t1_inv_x", 32'(inv_x), 32'd1);
    check("t1_state_issue", 32'(dbg_state), 32'd1);
    req = '0;
    step();
    check("t1_ack_off", 32'(ack), 32'd0);
    check("t1_en_b", 32'(inv_enable), 32'd1);
    step();
    check("t1_en_c", 32'(inv_enable), 32'd0);
    check("t1_state_wait", 32'(dbg_state), 32'd2);
    n = 0;
    en_extra = 0;
    while (done === '0 && n < 60) begin
      step();
      n++;
      if (inv_enable === 1'b1) en_extra++;
    end
    check("t1_done", 32'(done), 32'b0001);
    check("t1_result", 32'(result), 32'd1);
    check("t1_en_extra", 32'(en_extra), 32'd0);
    step();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_off", 32'(done), 32'd0);
    check("t1_result_hold", 32'(result), 32'd1);

    // Inverse of 2 is (p+1)/2; inverse of p-1 is p-1
    operand[2*DW +: DW] = 16'd2;
    req = 4'b0100;
    serve("t2", 2, 16'd32761, 1'b0, w);
    operand[3*DW +: DW] = 16'd65520;
    req = 4'b1000;
    serve("t3", 3, 16'd65520, 1'b0, w);

    // Contention from ptr=0: grants 0,1,2,3
    ops[0] = 16'd1;  exps[0] = 16'd1;
    ops[1] = 16'd2;  exps[1] = 16'd32761;
    ops[2] = 16'd3;  exps[2] = 16'd43681;
    ops[3] = 16'd65520; exps[3] = 16'd65520;
    step();
    for (int i = 0; i < NR; i++) operand[i*DW +: DW] = ops[i];
    req = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      serve($sformatf("rr%0d", i), i, exps[i], 1'b0, w);
      if (i > 0) check($sformatf("rr%0d_ack_gap", i), 32'(w), 32'd2);
    end

    // Fairness: 0 re-requests after each done while 3 holds
    step();
    operand[0*DW +: DW] = 16'd1;
    operand[3*DW +: DW] = 16'd2;
    req = 4'b1001;
    serve("fair0", 0, 16'd1, 1'b1, w);
    serve("fair3", 3, 16'd32761, 1'b1, w);
    serve("fair0b", 0, 16'd1, 1'b0, w);

    // Reset while waiting on the unit
    step();
    operand[1*DW +: DW] = 16'd5;
    req = 4'b0010;
    n = 0;
    while (ack === '0 && n < 20) begin
      step();
      n++;
    end
    check("mid_ack", 32'(ack), 32'b0010);
    req = '0;
    step();
    step();
    check("mid_state_wait", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_en", 32'(inv_enable), 32'd0);
    check("mid_rst_inv_x", 32'(inv_x), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (done !== '0) seen++;
    end
    check("mid_no_done", 32'(seen), 32'd0);
    check("mid_stale_ready", 32'(inv_ready), 32'd1);
    operand[2*DW +: DW] = 16'd3;
    req = 4'b0100;
    serve("post_rst", 2, 16'd43681, 1'b0, w);

`ifdef INV_ZERO_CHECK_EN
    // Zero operand bypasses the unit
    step();
    operand[0*DW +: DW] = '0;
    req = 4'b0001;
    step();
    check("zero_ack", 32'(ack), 32'b0001);
    req = '0;
    en_extra = (inv_enable === 1'b1) ? 1 : 0;
    n = 0;
    while (done === '0 && n < 2) begin
      step();
      n++;
      if (inv_enable === 1'b1) en_extra++;
    end
    check("zero_done", 32'(done), 32'b0001);
    check("zero_result", 32'(result), 32'd0);
    check("zero_err", 32'(err), 32'd1);
    check("zero_no_enable", 32'(en_extra), 32'd0);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
